// File: rtl/cim_phase_seq.sv
// cim_phase_seq: CIM calibration/compute phase sequencer (SET, then N_PASS passes with WAIT/INBIT windows).
// Optional abort/aborted ports are enabled by defining SEQ_ABORT_EN.
module cim_phase_seq #(
    parameter int SET_LEN   = 2,
    parameter int N_PASS    = 2,
    parameter int PASS_LEN  = 5,
    parameter int WAIT_LEN  = 3,
    parameter int INBIT_OFS = 1,
    localparam int PIDX_W   = $clog2(N_PASS) > 0 ? $clog2(N_PASS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_b,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              set,
    output logic              comp,
    output logic              model,
    output logic              wait_,
    output logic              inbit,
    output logic              busy,
    output logic [PIDX_W-1:0] pass_idx,
    output logic              cal_done
);
    localparam int CMAX  = SET_LEN > PASS_LEN ? SET_LEN : PASS_LEN;
    localparam int CNT_W = $clog2(CMAX + 1);

    if (WAIT_LEN > PASS_LEN || WAIT_LEN < 1) begin : g_bad_wait
        $error("cim_phase_seq: WAIT_LEN must be in 1..PASS_LEN");
    end
    if (INBIT_OFS >= WAIT_LEN) begin : g_bad_inbit
        $error("cim_phase_seq: INBIT_OFS must be below WAIT_LEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_SET, S_PASS, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIDX_W-1:0]  pidx_q, pidx_d;
    logic set_q, comp_q, model_q, wait_q, inbit_q, busy_q, done_q;
    logic set_d, comp_d, model_d, wait_d, inbit_d, busy_d, done_d;
`ifdef SEQ_ABORT_EN
    logic aborted_q, aborted_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pidx_d  = pidx_q;
        case (state_q)
            S_IDLE: if (cal_b) begin
                state_d = S_SET;
                cnt_d   = '0;
            end
            S_SET: if (cnt_q == CNT_W'(SET_LEN - 1)) begin
                state_d = S_PASS;
                cnt_d   = '0;
                pidx_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_PASS: if (cnt_q == CNT_W'(PASS_LEN - 1)) begin
                cnt_d = '0;
                if (pidx_q == PIDX_W'(N_PASS - 1)) begin
                    state_d = S_DONE;
                    pidx_d  = '0;
                end else begin
                    pidx_d = pidx_q + PIDX_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: if (!cal_b) state_d = S_IDLE;
        endcase
`ifdef SEQ_ABORT_EN
        aborted_d = abort && (state_q == S_SET || state_q == S_PASS);
        if (aborted_d) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pidx_d  = '0;
        end
`endif
        // strobes are decoded from the next state so the output flops line up with the state register
        set_d   = state_d == S_SET;
        comp_d  = state_d == S_PASS;
        wait_d  = comp_d && cnt_d < CNT_W'(WAIT_LEN);
        inbit_d = wait_d && cnt_d >= CNT_W'(INBIT_OFS);
        model_d = comp_d && pidx_d == PIDX_W'(N_PASS - 1);
        busy_d  = set_d || comp_d;
        done_d  = state_d == S_DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pidx_q  <= '0;
            set_q   <= 1'b0;
            comp_q  <= 1'b0;
            model_q <= 1'b0;
            wait_q  <= 1'b0;
            inbit_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pidx_q  <= pidx_d;
            set_q   <= set_d;
            comp_q  <= comp_d;
            model_q <= model_d;
            wait_q  <= wait_d;
            inbit_q <= inbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign set      = set_q | !rst;
    assign comp     = comp_q;
    assign model    = model_q;
    assign wait_    = wait_q;
    assign inbit    = inbit_q;
    assign busy     = busy_q;
    assign pass_idx = pidx_q;
    assign cal_done = done_q;
`ifdef SEQ_ABORT_EN
    assign aborted  = aborted_q;
`endif
endmodule

// File: tb/tb_cim_phase_seq.sv
// tb_cim_phase_seq: checks a default-parameter and an alternate-parameter sequencer against a run-position model.
// Abort checks are compiled in when SEQ_ABORT_EN is defined.
module tb_cim_phase_seq;
    localparam int SL0 = 2, NP0 = 2, PL0 = 5, WL0 = 3, IO0 = 1, B0 = SL0 + NP0 * PL0;
    localparam int SL1 = 2, NP1 = 3, PL1 = 4, WL1 = 2, IO1 = 1, B1 = SL1 + NP1 * PL1;

    logic clk, rst, cal_b;
    logic set0, comp0, model0, wait0, inbit0, busy0, done0;
    logic set1, comp1, model1, wait1, inbit1, busy1, done1;
    logic [0:0] pidx0;
    logic [1:0] pidx1;
    logic [8:0] obs0, obs1;
    int n_chk = 0, n_fail = 0;
    int t0 = 0, t1 = 0;
    int cnt_a, cnt_b;
`ifdef SEQ_ABORT_EN
    logic abort, ab0, ab1;
`endif

    cim_phase_seq u0 (
        .clk(clk), .rst(rst), .cal_b(cal_b),
`ifdef SEQ_ABORT_EN
        .abort(abort), .aborted(ab0),
`endif
        .set(set0), .comp(comp0), .model(model0), .wait_(wait0), .inbit(inbit0),
        .busy(busy0), .pass_idx(pidx0), .cal_done(done0)
    );

    cim_phase_seq #(.SET_LEN(SL1), .N_PASS(NP1), .PASS_LEN(PL1), .WAIT_LEN(WL1), .INBIT_OFS(IO1)) u1 (
        .clk(clk), .rst(rst), .cal_b(cal_b),
`ifdef SEQ_ABORT_EN
        .abort(abort), .aborted(ab1),
`endif
        .set(set1), .comp(comp1), .model(model1), .wait_(wait1), .inbit(inbit1),
        .busy(busy1), .pass_idx(pidx1), .cal_done(done1)
    );

    assign obs0 = {set0, comp0, wait0, inbit0, model0, busy0, done0, 1'b0, pidx0};
    assign obs1 = {set1, comp1, wait1, inbit1, model1, busy1, done1, pidx1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector {set,comp,wait_,inbit,model,busy,cal_done,pass_idx[1:0]} at run position t:
    // 0 idle, 1..busy_len inside the run, busy_len+1 done.
    function automatic logic [8:0] exp_out(int t, int sl, int np, int pl, int wl, int io);
        int b = sl + np * pl;
        int p, o;
        logic [8:0] v = '0;
        if (t >= 1 && t <= sl) begin
            v[8] = 1'b1;
            v[3] = 1'b1;
        end else if (t > sl && t <= b) begin
            p = (t - sl - 1) / pl;
            o = (t - sl - 1) % pl;
            v[7] = 1'b1;
            v[6] = o < wl;
            v[5] = o >= io && o < wl;
            v[4] = p == np - 1;
            v[3] = 1'b1;
            v[1:0] = p[1:0];
        end else if (t == b + 1) begin
            v[2] = 1'b1;
        end
        return v;
    endfunction

    function automatic int next_t(int t, logic cb, int b);
        if (t == 0) return cb ? 1 : 0;
        if (t <= b) return t + 1;
        return cb ? t : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic cyc(input logic cb);
`ifdef SEQ_ABORT_EN
        logic ea0, ea1;
`endif
        cal_b = cb;
        @(posedge clk);
`ifdef SEQ_ABORT_EN
        ea0 = abort && t0 >= 1 && t0 <= B0;
        ea1 = abort && t1 >= 1 && t1 <= B1;
        t0 = ea0 ? 0 : next_t(t0, cb, B0);
        t1 = ea1 ? 0 : next_t(t1, cb, B1);
`else
        t0 = next_t(t0, cb, B0);
        t1 = next_t(t1, cb, B1);
`endif
        #1;
        chk("u0_outputs", obs0, exp_out(t0, SL0, NP0, PL0, WL0, IO0));
        chk("u1_outputs", obs1, exp_out(t1, SL1, NP1, PL1, WL1, IO1));
`ifdef SEQ_ABORT_EN
        chk("u0_aborted", ab0, ea0);
        chk("u1_aborted", ab1, ea1);
`endif
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        chk("u0_async_reset", obs0, 9'h100);
        chk("u1_async_reset", obs1, 9'h100);
        #1;
        rst = 1'b1;
        t0 = 0;
        t1 = 0;
    endtask

    typedef struct packed {logic cal_b; logic [8:0] e;} vec_t;
    vec_t tbl [16];

    initial begin
        // legacy 12-step map: set 1-2, comp 3-12, wait 3-5/8-10, inbit 4-5/9-10, model 8-12, then done
        tbl = '{'{1'b1, 9'h108}, '{1'b1, 9'h108}, '{1'b1, 9'h0C8}, '{1'b1, 9'h0E8},
                '{1'b1, 9'h0E8}, '{1'b1, 9'h088}, '{1'b1, 9'h088}, '{1'b1, 9'h0D9},
                '{1'b1, 9'h0F9}, '{1'b1, 9'h0F9}, '{1'b1, 9'h099}, '{1'b1, 9'h099},
                '{1'b1, 9'h004}, '{1'b1, 9'h004}, '{1'b0, 9'h000}, '{1'b0, 9'h000}};
        rst = 1'b0;
        cal_b = 1'b0;
`ifdef SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("u0_reset_state", obs0, 9'h100);
        chk("u1_reset_state", obs1, 9'h100);
        rst = 1'b1;
        cyc(1'b0);

        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            cal_b = tbl[i].cal_b;
            @(posedge clk);
            t0 = next_t(t0, tbl[i].cal_b, B0);
            t1 = next_t(t1, tbl[i].cal_b, B1);
            #1;
            chk($sformatf("u0_table_row%0d", i), obs0, tbl[i].e);
            chk("u1_outputs", obs1, exp_out(t1, SL1, NP1, PL1, WL1, IO1));
            cnt_a += int'(busy1);
            cnt_b += int'(inbit1);
        end
        chk("u1_busy_cycles", cnt_a, 14);
        chk("u1_inbit_cycles", cnt_b, 3);

        cyc(1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0);
            cnt_a += int'(done0);
            cnt_b += int'(done1);
        end
        chk("u0_pulse_done_cycles", cnt_a, 1);
        chk("u1_pulse_done_cycles", cnt_b, 1);

        repeat (15) cyc(1'b1);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            cnt_a += int'(busy0) + int'(busy1);
        end
        chk("held_high_no_restart", cnt_a, 0);
        cyc(1'b0);
        cyc(1'b1);
        chk("u0_restart_busy", busy0, 1'b1);

        repeat (9) cyc(1'b1);
        chk("u0_pass1_ofs2_idx", pidx0, 1'b1);
        async_reset();
        cyc(1'b1);
        chk("u0_clean_set_after_reset", {set0, busy0}, 2'b11);
        repeat (20) cyc(1'b0);

`ifdef SEQ_ABORT_EN
        repeat (4) cyc(1'b1);
        abort = 1'b1;
        cyc(1'b0);
        abort = 1'b0;
        chk("u0_abort_pulse", ab0, 1'b1);
        cnt_a = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0);
            cnt_a += int'(done0) + int'(ab0);
        end
        chk("u0_no_done_after_abort", cnt_a, 0);
`endif

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
`ifdef SEQ_ABORT_EN
            abort = $urandom_range(0, 19) == 0;
`endif
            cyc($urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
